// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, fills a small prefetch queue, and flushes it on redirect.
// Optional FETCH_PERF_EN adds issue/bubble/flush counters.
`timescale 1ns/1ps
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned IMEM_WORDS = 11
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_bubbles,
  output logic [15:0] perf_flushes
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS * 4);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        q_data [DEPTH];
  logic [31:0]        q_pc   [DEPTH];

  logic empty;
  logic full;
  logic in_range;
  logic pop;
  logic push;
  logic unused_redirect_lsbs;

  assign empty    = (count == '0);
  assign full     = (count == CNT_FULL);
  assign in_range = (fetch_pc < PC_LIMIT);
  assign pop      = !empty && inst_ready;
  // A full queue can still accept a word when the head leaves in the same cycle.
  assign push     = (state == RUN) && in_range && (!full || pop) && !redirect_valid;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // PC, queue pointers/occupancy and run/halt state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      state    <= RUN;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if ((state == RUN) && !in_range) begin
        state <= HALT;
      end
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        fetch_pc <= fetch_pc + 32'd4;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage needs no reset; entries are only visible while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= fetch_pc;
    end
  end

  assign imem_addr  = fetch_pc;
  assign inst_valid = !empty;
  assign inst_data  = empty ? 32'h0 : q_data[rd_ptr];
  assign inst_pc    = empty ? 32'h0 : q_pc[rd_ptr];
  assign fault      = (state == HALT) && empty;

`ifdef FETCH_PERF_EN
  // Free-running wrap-around performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued  <= '0;
      perf_bubbles <= '0;
      perf_flushes <= '0;
    end else begin
      if (pop)                 perf_issued  <= perf_issued + 32'd1;
      if (inst_ready && empty) perf_bubbles <= perf_bubbles + 32'd1;
      if (redirect_valid)      perf_flushes <= perf_flushes + 16'd1;
    end
  end
`endif

endmodule
